// File: rtl/seq_div_pkg.sv
// seq_div_pkg: FSM encodings and divide-by-zero constant shared by the divider files.
package seq_div_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'h0,
        CHECK = 4'h1,
        ITER  = 4'h2,
        DONE  = 4'h5
    } state_t;

    // Quotient reported for a zero divisor: all ones at any width (sliced by the user).
    localparam logic [31:0] DBZ_QUO = '1;

endpackage

// File: rtl/seq_div_step.sv
// seq_div_step: one restoring-division iteration on {rem, quo}, purely combinational.
module seq_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [2*WIDTH:0] sh;
    logic [WIDTH:0]   trial;

    // A clear trial MSB means the shifted remainder covered the divisor.
    always_comb begin
        sh       = {rem, quo} << 1;
        trial    = sh[2*WIDTH:WIDTH] - {1'b0, divisor};
        rem_next = trial[WIDTH] ? sh[2*WIDTH:WIDTH] : trial;
        quo_next = sh[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~trial[WIDTH]};
    end

endmodule

// File: rtl/seq_div.sv
// seq_div: iterative unsigned restoring divider, one quotient bit per clock,
// with valid/ready handshakes on the operand and result sides.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_next;
    logic [WIDTH:0]   rem, rem_step;
    logic [WIDTH-1:0] quo, quo_step, dvs;
    logic [CW-1:0]    cnt;

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (dvs),
        .rem_next(rem_step),
        .quo_next(quo_step)
    );

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = in_valid ? CHECK : IDLE;
            CHECK:   state_next = dvs == '0 ? DONE : ITER;
            ITER:    state_next = cnt == CW'(1) ? DONE : ITER;
            DONE:    state_next = out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Result registers load only on the way into DONE, so a partial quotient never shows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        quo <= dividend;
                        dvs <= divisor;
                        rem <= '0;
                    end
                end
                CHECK: begin
                    if (dvs == '0) begin
                        quotient    <= DBZ_QUO[WIDTH-1:0];
                        remainder   <= quo;
                        div_by_zero <= 1'b1;
                    end else begin
                        cnt         <= CW'(WIDTH);
                        div_by_zero <= 1'b0;
                    end
                end
                ITER: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        quotient  <= quo_step;
                        remainder <= rem_step[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed and randomized checks of seq_div against an arithmetic model
// (a / b, a % b, all-ones on zero divisor) with per-cycle comparison of the result port.
module tb_seq_div;

    localparam int W = 8;

    logic         clk = 1'b0, rst = 1'b1;
    logic         in_valid = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid, div_by_zero;
    logic [W-1:0] dividend = '0, divisor = '0, quotient, remainder;

    logic         in_valid16 = 1'b0, out_ready16 = 1'b1;
    logic         in_ready16, out_valid16, dbz16;
    logic [15:0]  dividend16 = '0, divisor16 = '0, quotient16, remainder16;

    int checks = 0, errors = 0, cyc = 0;
    bit prev_ov = 1'b0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           acc;
    } exp_t;
    exp_t exp_q[$];

    seq_div #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    seq_div #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .dividend(dividend16), .divisor(divisor16), .out_valid(out_valid16),
        .out_ready(out_ready16), .quotient(quotient16), .remainder(remainder16),
        .div_by_zero(dbz16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        exp_t e;
        e.q   = (b == 0) ? '1 : a / b;
        e.r   = (b == 0) ? a : a % b;
        e.z   = (b == 0);
        e.acc = acc;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_div();
        int s = $urandom_range(0, 7);
        return (s == 0) ? '0 : (s < 3) ? W'($urandom_range(1, 3)) : W'($urandom);
    endfunction

    // Scoreboard: push on accept, pop on result handshake; cyc counts posedges.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_q.delete();
        else begin
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) exp_q.push_back(model(dividend, divisor, cyc));
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_valid_exclusive", {31'b0, in_ready & out_valid}, 0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_result: got out_valid=1 expected no pending operation");
                end else begin
                    chk("model_quotient", quotient, exp_q[0].q);
                    chk("model_remainder", remainder, exp_q[0].r);
                    chk("model_div_by_zero", div_by_zero, exp_q[0].z);
                    if (!prev_ov) chk("model_latency", cyc - exp_q[0].acc, exp_q[0].z ? 2 : W + 2);
                end
            end
            prev_ov = out_valid;
        end else prev_ov = 1'b0;
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Latency counts edges from the accept edge to the first edge that sees out_valid high.
    task automatic wait_result(output int lat);
        int n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: got out_valid=0 expected 1 within 60 cycles");
        end
        lat = n + 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int w, lat, n;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_by_zero", div_by_zero, 0);
        chk("rst_in_ready16", in_ready16, 1);
        rst = 1'b0;
        @(negedge clk);

        send(8'd100, 8'd7, w);
        wait_result(lat);
        chk("d100_7_latency", lat, 10);
        chk("d100_7_quotient", quotient, 14);
        chk("d100_7_remainder", remainder, 2);
        chk("d100_7_dbz", div_by_zero, 0);
        @(negedge clk);
        chk("d100_7_ready_after", in_ready, 1);

        send(8'd255, 8'd1, w);
        wait_result(lat);
        chk("d255_1_quotient", quotient, 255);
        chk("d255_1_remainder", remainder, 0);
        chk("d255_1_latency", lat, 10);
        send(8'd3, 8'd200, w);
        chk("b2b_accept_gap", w, 1);
        wait_result(lat);
        chk("d3_200_quotient", quotient, 0);
        chk("d3_200_remainder", remainder, 3);
        chk("d3_200_latency", lat, 10);
        @(negedge clk);

        send(8'd5, 8'd0, w);
        wait_result(lat);
        chk("d5_0_latency", lat, 2);
        chk("d5_0_quotient", quotient, 8'hFF);
        chk("d5_0_remainder", remainder, 5);
        chk("d5_0_dbz", div_by_zero, 1);
        @(negedge clk);

        out_ready = 1'b0;
        send(8'd200, 8'd13, w);
        wait_result(lat);
        repeat (5) begin
            in_valid = 1'b1;
            dividend = W'($urandom);
            divisor  = W'($urandom);
            chk("stall_quotient", quotient, 15);
            chk("stall_remainder", remainder, 5);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_released_ready", in_ready, 1);
        repeat (W + 4) begin
            chk("stall_no_extra_result", out_valid, 0);
            @(negedge clk);
        end

        send(8'd77, 8'd3, w);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        chk("midrst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            chk("midrst_no_result", out_valid, 0);
        end
        send(8'd9, 8'd4, w);
        wait_result(lat);
        chk("d9_4_quotient", quotient, 2);
        chk("d9_4_remainder", remainder, 1);
        chk("d9_4_latency", lat, 10);
        @(negedge clk);

        in_valid16 = 1'b1;
        dividend16 = 16'd65535;
        divisor16  = 16'd255;
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0;
        divisor16  = 16'd0;
        n = 0;
        while (!out_valid16 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("w16_latency", n + 1, 18);
        chk("w16_quotient", quotient16, 257);
        chk("w16_remainder", remainder16, 0);
        chk("w16_dbz", dbz16, 0);

        repeat (1500) begin
            in_valid  = 1'($urandom_range(0, 1));
            dividend  = W'($urandom);
            divisor   = rnd_div();
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
